booth_result_acc: RTL and testbench
===================================

# booth_result_acc

Downstream consumer of the Booth multiplier. It captures each signed product when the multiplier's `done` rises and sign-extends it. It accumulates N_TERMS products into a wider running sum, then presents that sum over a valid/ready handshake. Together with the multiplier it forms a sequential multiply-accumulate (dot-product) path.

## Interface
- `PROD_W`, 10: product width; matches the multiplier `c` output (2 × 5-bit operands).
- `ACC_W`, 16: accumulator and `sum_out` width; must be ≥ `PROD_W`.
- `N_TERMS`, 4: products per group; must be ≥ 1.
- `clk`  in  1  rising-edge clock, shared with the multiplier.
- `rst`  in  1  asynchronous reset, active-high.
- `prod_in`  in  PROD_W  two's-complement product (multiplier `c`).
- `prod_done`  in  1  multiplier `done`; may stay high for many cycles.
- `clr`  in  1  synchronous group abort/clear.
- `sum_out`  out  ACC_W  completed group sum; stable while `sum_valid`=1.
- `sum_valid`  out  1  group sum available.
- `sum_ready`  in  1  consumer accepts `sum_out`.
- `count`  out  $clog2(N_TERMS+1)  products accumulated in the current group.
- `overflow`  out  1  sticky: signed overflow occurred in the current group.
- `dropped`  out  1  sticky: a product arrived while a sum was pending and was lost.

## Operation
- Capture event: `prod_done`=1 and registered `done_q`=0. A held-high `done` yields exactly one capture. `done_q` resets to 1, so a `done` already high when reset deasserts is not captured.
- State machine:
  - ACCUM: on capture, `acc <= acc + sext(prod_in)` and `count++`. If that capture is the N_TERMS-th, `sum_out <= new acc`, `sum_valid <= 1`, and the FSM goes to HOLD.
  - HOLD: `acc` and `sum_out` are frozen. A capture here sets `dropped` and changes nothing else.
  - HOLD, `sum_valid & sum_ready`: `acc <= 0`, `count <= 0`, `overflow` and `dropped` clear, `sum_valid <= 0`, FSM goes to ACCUM.
  - Handshake and capture in the same cycle: the product becomes term 1 of the next group (`acc <= sext(prod_in)`, `count <= 1`). It is not dropped.
- `clr` (priority over everything except `rst`): `acc`, `count`, `sum_valid`, `overflow` and `dropped` all go to 0, and the FSM goes to ACCUM. `done_q` still updates normally. A capture in the `clr` cycle is discarded.
- Arithmetic: `ACC_W+1`-bit sum of the sign-extended operands. Overflow means the result's sign disagrees with both operand signs. Overflow handling depends on `BOOTH_ACC_SAT_EN` (see Configuration).
- Reset values: `sum_out`=0, `sum_valid`=0, `count`=0, `overflow`=0, `dropped`=0, `acc`=0, state ACCUM, `done_q`=1.

## Timing
- Capture is decided combinationally in the cycle `done` rises. `acc` and `count` update on the following edge.
- `sum_valid` rises on the same edge that registers the N-th term: 1-cycle latency from the N-th `done` rise.
- Minimum spacing between captures: 2 cycles (`done` must be seen low once).
- Back-to-back groups are sustained with `sum_ready` tied high; no bubble beyond the handshake cycle.
- `rst` asserted mid-group or in HOLD clears all state immediately, with no clock required.

## Configuration
- `BOOTH_ACC_SAT_EN` defined: on overflow the sum clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and `overflow` is set.
- `BOOTH_ACC_SAT_EN` undefined: the sum wraps modulo 2^ACC_W, and `overflow` is still set.

## Structure
- Package `booth_pkg`:
  - default `PROD_W`/`ACC_W`/`N_TERMS` localparams
  - state enum {ACCUM, HOLD}
  - functions for the ACC_W signed max/min constants
- Sub-module `booth_sat_add`: combinational signed add with overflow detection, saturation under `BOOTH_ACC_SAT_EN`. The FSM, edge detector and flags live in the top module.

## Test plan
- Multiplier products -4, 48, 4, 45 (2×-2, 6×8, 4×1, 5×9), `sum_ready`=1 → `sum_valid` pulses once with `sum_out`=93 (0x005D); `overflow`=0 and `dropped`=0.
- `prod_done` held high 5 cycles with `prod_in`=48 → `count` increments by exactly 1; a second rise after one low cycle → `count`=2.
- `sum_ready`=0 after the group completes, then a fifth product 45 → `sum_out` stays 93 and `dropped`=1; raising `sum_ready` clears `dropped`, `count` returns to 0.
- `ACC_W`=10, products 256 ×4:
  - with `BOOTH_ACC_SAT_EN`: `sum_out`=511, `overflow`=1.
  - without `BOOTH_ACC_SAT_EN`: `sum_out`=0, `overflow`=1.
- `rst` pulsed after 2 products (`acc`=44) → all outputs 0 immediately; the next 4 products 1, 2, 3, 4 → `sum_out`=10.
- Handshake cycle coincident with a capture of 7 → the previous sum is accepted, and the new group starts with `count`=1 and finishes with the correct total.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared widths, FSM state type and signed-limit helpers for the Booth result accumulator.
// Optional saturation is selected by defining BOOTH_ACC_SAT_EN (see booth_sat_add).
package booth_pkg;

    localparam int BOOTH_PROD_W  = 10;
    localparam int BOOTH_ACC_W   = 16;
    localparam int BOOTH_N_TERMS = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Bit patterns of the most positive / most negative w-bit two's-complement values
    function automatic logic [63:0] signed_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] signed_min(input int w);
        return ~signed_max(w);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational W-bit signed adder with overflow flag.
// With BOOTH_ACC_SAT_EN defined the result clamps to the signed limits; otherwise it wraps.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int W = BOOTH_ACC_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {a[W-1], a} + {b[W-1], b};

    // The extra top bit holds the true sign; it disagrees with bit W-1 only on overflow
    assign ovf = full[W] ^ full[W-1];

`ifdef BOOTH_ACC_SAT_EN
    localparam logic [W-1:0] SAT_MAX = W'(signed_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(signed_min(W));

    assign sum = ovf ? (full[W] ? SAT_MIN : SAT_MAX) : full[W-1:0];
`else
    assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/booth_result_acc.sv
// Accumulates N_TERMS signed Booth products per group and offers the sum over valid/ready.
// Overflow behaviour follows booth_sat_add: saturating when BOOTH_ACC_SAT_EN is defined.
module booth_result_acc
    import booth_pkg::*;
#(
    parameter int PROD_W  = BOOTH_PROD_W,
    parameter int ACC_W   = BOOTH_ACC_W,
    parameter int N_TERMS = BOOTH_N_TERMS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PROD_W-1:0]            prod_in,
    input  logic                         prod_done,
    input  logic                         clr,
    output logic [ACC_W-1:0]             sum_out,
    output logic                         sum_valid,
    input  logic                         sum_ready,
    output logic [$clog2(N_TERMS+1)-1:0] count,
    output logic                         overflow,
    output logic                         dropped
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    acc_state_t       state;
    logic             done_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             capture;
    logic             handshake;
    logic [CNT_W-1:0] count_base;
    logic [CNT_W-1:0] count_next;
    logic             last_term;

    generate
        if (ACC_W > PROD_W) begin : g_sext
            assign prod_ext = {{(ACC_W - PROD_W){prod_in[PROD_W-1]}}, prod_in};
        end else begin : g_noext
            assign prod_ext = prod_in;
        end
    endgenerate

    assign capture   = prod_done & ~done_q;
    assign handshake = sum_valid & sum_ready;

    // A capture in the handshake cycle starts a fresh group, so the adder sees zero instead of acc
    assign add_a      = handshake ? '0 : acc;
    assign count_base = handshake ? '0 : count;
    assign count_next = count_base + 1'b1;
    assign last_term  = (count_next == CNT_W'(N_TERMS));

    booth_sat_add #(
        .W(ACC_W)
    ) u_add (
        .a  (add_a),
        .b  (prod_ext),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            done_q    <= 1'b1;
            acc       <= '0;
            count     <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overflow  <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            done_q <= prod_done;
            if (clr) begin
                state     <= ACCUM;
                acc       <= '0;
                count     <= '0;
                sum_valid <= 1'b0;
                overflow  <= 1'b0;
                dropped   <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (capture) begin
                            acc      <= add_sum;
                            count    <= count_next;
                            overflow <= overflow | add_ovf;
                            if (last_term) begin
                                sum_out   <= add_sum;
                                sum_valid <= 1'b1;
                                state     <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (handshake) begin
                            sum_valid <= 1'b0;
                            dropped   <= 1'b0;
                            state     <= ACCUM;
                            if (capture) begin
                                acc      <= add_sum;
                                count    <= count_next;
                                overflow <= add_ovf;
                                if (last_term) begin
                                    sum_out   <= add_sum;
                                    sum_valid <= 1'b1;
                                    state     <= HOLD;
                                end
                            end else begin
                                acc      <= '0;
                                count    <= '0;
                                overflow <= 1'b0;
                            end
                        end else if (capture) begin
                            dropped <= 1'b1;
                        end
                    end
                    default: state <= ACCUM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_booth_result_acc.sv
// Directed self-checking bench for booth_result_acc (default 16-bit and a 10-bit accumulator).
// Expected results for the overflow case depend on BOOTH_ACC_SAT_EN.
module tb_booth_result_acc;

    logic       clk;
    logic       rst;
    logic [9:0] prod_in;
    logic       prod_done;
    logic       clr;
    logic       sum_ready;
    logic [15:0] sum_out;
    logic       sum_valid;
    logic [2:0] count;
    logic       overflow;
    logic       dropped;

    logic [9:0] prodIn10;
    logic       prodDone10;
    logic       sumReady10;
    logic [9:0] sumOut10;
    logic       sumValid10;
    logic [2:0] count10;
    logic       overflow10;
    logic       dropped10;

    int checks;
    int failures;

    booth_result_acc dut (
        .clk      (clk),
        .rst      (rst),
        .prod_in  (prod_in),
        .prod_done(prod_done),
        .clr      (clr),
        .sum_out  (sum_out),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .count    (count),
        .overflow (overflow),
        .dropped  (dropped)
    );

    booth_result_acc #(
        .PROD_W (10),
        .ACC_W  (10),
        .N_TERMS(4)
    ) dut10 (
        .clk      (clk),
        .rst      (rst),
        .prod_in  (prodIn10),
        .prod_done(prodDone10),
        .clr      (1'b0),
        .sum_out  (sumOut10),
        .sum_valid(sumValid10),
        .sum_ready(sumReady10),
        .count    (count10),
        .overflow (overflow10),
        .dropped  (dropped10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One capture: done high for one cycle then low for one, returning at a falling edge
    task automatic applyStimulus(input logic [9:0] p);
        @(negedge clk);
        prod_in   = p;
        prod_done = 1'b1;
        @(negedge clk);
        prod_done = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [9:0] expSat;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        prod_in    = '0;
        prod_done  = 1'b0;
        clr        = 1'b0;
        sum_ready  = 1'b1;
        prodIn10   = '0;
        prodDone10 = 1'b0;
        sumReady10 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_sum_out", 32'(sum_out), 0);
        checkOutput("reset_sum_valid", 32'(sum_valid), 0);
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_overflow", 32'(overflow), 0);
        checkOutput("reset_dropped", 32'(dropped), 0);

        // Basic group: -4 + 48 + 4 + 45 = 93
        applyStimulus(10'h3FC);
        applyStimulus(10'd48);
        applyStimulus(10'd4);
        checkOutput("grp1_count3", 32'(count), 3);
        checkOutput("grp1_valid_early", 32'(sum_valid), 0);
        applyStimulus(10'd45);
        checkOutput("grp1_valid", 32'(sum_valid), 1);
        checkOutput("grp1_sum", 32'(sum_out), 93);
        checkOutput("grp1_overflow", 32'(overflow), 0);
        checkOutput("grp1_dropped", 32'(dropped), 0);
        @(negedge clk);
        checkOutput("grp1_valid_pulse", 32'(sum_valid), 0);
        checkOutput("grp1_count_clr", 32'(count), 0);

        // Held-high done gives exactly one capture
        prod_in   = 10'd48;
        prod_done = 1'b1;
        repeat (5) @(negedge clk);
        prod_done = 1'b0;
        @(negedge clk);
        checkOutput("held_done_count", 32'(count), 1);
        applyStimulus(10'd48);
        checkOutput("second_rise_count", 32'(count), 2);

        // Synchronous clear aborts the partial group
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_count", 32'(count), 0);

        // Stalled consumer: extra product is dropped
        sum_ready = 1'b0;
        applyStimulus(10'h3FC);
        applyStimulus(10'd48);
        applyStimulus(10'd4);
        applyStimulus(10'd45);
        @(negedge clk);
        checkOutput("stall_valid", 32'(sum_valid), 1);
        checkOutput("stall_sum", 32'(sum_out), 93);
        applyStimulus(10'd45);
        checkOutput("drop_flag", 32'(dropped), 1);
        checkOutput("drop_sum_frozen", 32'(sum_out), 93);
        checkOutput("drop_count_frozen", 32'(count), 4);
        sum_ready = 1'b1;
        @(negedge clk);
        checkOutput("accept_dropped", 32'(dropped), 0);
        checkOutput("accept_count", 32'(count), 0);
        checkOutput("accept_valid", 32'(sum_valid), 0);

        // Asynchronous reset mid-group
        applyStimulus(10'd20);
        applyStimulus(10'd24);
        checkOutput("pre_rst_count", 32'(count), 2);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_count", 32'(count), 0);
        checkOutput("async_rst_sum", 32'(sum_out), 0);
        checkOutput("async_rst_valid", 32'(sum_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(10'd1);
        applyStimulus(10'd2);
        applyStimulus(10'd3);
        applyStimulus(10'd4);
        checkOutput("post_rst_sum", 32'(sum_out), 10);
        checkOutput("post_rst_valid", 32'(sum_valid), 1);

        // Handshake coincident with a capture of 7
        @(negedge clk);
        sum_ready = 1'b0;
        applyStimulus(10'd1);
        applyStimulus(10'd1);
        applyStimulus(10'd1);
        applyStimulus(10'd1);
        checkOutput("hs_prev_sum", 32'(sum_out), 4);
        @(negedge clk);
        sum_ready = 1'b1;
        prod_in   = 10'd7;
        prod_done = 1'b1;
        @(negedge clk);
        prod_done = 1'b0;
        checkOutput("hs_new_count", 32'(count), 1);
        checkOutput("hs_valid_low", 32'(sum_valid), 0);
        checkOutput("hs_not_dropped", 32'(dropped), 0);
        applyStimulus(10'd10);
        applyStimulus(10'd20);
        applyStimulus(10'd30);
        checkOutput("hs_group_sum", 32'(sum_out), 67);
        checkOutput("hs_group_valid", 32'(sum_valid), 1);

        // 10-bit accumulator overflow: 256 x 4
`ifdef BOOTH_ACC_SAT_EN
        expSat = 10'd511;
`else
        expSat = 10'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            prodIn10   = 10'd256;
            prodDone10 = 1'b1;
            @(negedge clk);
            prodDone10 = 1'b0;
        end
        checkOutput("ovf10_valid", 32'(sumValid10), 1);
        checkOutput("ovf10_sum", 32'(sumOut10), 32'(expSat));
        checkOutput("ovf10_flag", 32'(overflow10), 1);
        checkOutput("ovf10_dropped", 32'(dropped10), 0);
        sumReady10 = 1'b1;
        @(negedge clk);
        checkOutput("ovf10_flag_cleared", 32'(overflow10), 0);
        checkOutput("ovf10_count_cleared", 32'(count10), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
